// File: rtl/ace_pkg.sv
// ACE snoop channel types shared by the snoop-port buffer.
// CR response bit positions, counters and bundle structs.
package ace_pkg;

  localparam int unsigned CR_DATA_TRANSFER_BIT = 0;
  localparam int unsigned CR_ERROR_BIT         = 1;
  localparam int unsigned CR_PASS_DIRTY_BIT    = 2;
  localparam int unsigned CR_IS_SHARED_BIT     = 3;
  localparam int unsigned CR_WAS_UNIQUE_BIT    = 4;

  typedef logic [7:0] snoop_cnt_t;
  typedef logic [4:0] cr_resp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  snoop;
    logic [2:0]  prot;
  } ac_chan_t;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } cd_chan_t;

  typedef struct packed {
    logic     ac_valid;
    ac_chan_t ac;
    logic     cr_ready;
    logic     cd_ready;
  } ace_snoop_req_t;

  typedef struct packed {
    logic     ac_ready;
    logic     cr_valid;
    cr_resp_t cr_resp;
    logic     cd_valid;
    cd_chan_t cd;
  } ace_snoop_resp_t;

  function automatic logic cr_has_data(input cr_resp_t r);
    return r[CR_DATA_TRANSFER_BIT];
  endfunction

endpackage

// File: rtl/snoop_sync_fifo.sv
// Registered synchronous FIFO, no fall-through.
// Push while full and pop while empty are ignored.
module snoop_sync_fifo #(
  parameter int unsigned Depth = 2,
  parameter type         T     = logic
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  T     data_i,
  input  logic pop_i,
  output T     data_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [CntW-1:0] cnt_t;

  localparam ptr_t LastPtr = ptr_t'(Depth - 1);
  localparam cnt_t FullCnt = cnt_t'(Depth);

  T     mem_q [Depth];
  ptr_t wr_q, wr_d;
  ptr_t rd_q, rd_d;
  cnt_t cnt_q, cnt_d;
  logic do_push, do_pop;

  assign full_o  = (cnt_q == FullCnt);
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_q];

  // Next pointers and occupancy
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) begin
      wr_d = (wr_q == LastPtr) ? '0 : wr_q + ptr_t'(1);
    end
    if (do_pop) begin
      rd_d = (rd_q == LastPtr) ? '0 : rd_q + ptr_t'(1);
    end
    unique case (1'b1)
      (do_push && !do_pop): cnt_d = cnt_q + cnt_t'(1);
      (do_pop && !do_push): cnt_d = cnt_q - cnt_t'(1);
      default:              cnt_d = cnt_q;
    endcase
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage: data only, no reset needed
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_q] <= data_i;
    end
  end

endmodule

// File: rtl/ace_snoop_port_buffer.sv
// Snoop-port stage between CCU and one ACE cache.
// Buffers AC/CR/CD, limits outstanding snoops, orders CD after CR.
module ace_snoop_port_buffer
  import ace_pkg::*;
#(
  parameter int unsigned AcDepth        = 2,
  parameter int unsigned CrDepth        = 2,
  parameter int unsigned CdDepth        = 4,
  parameter int unsigned MaxOutstanding = 4,
  parameter type         snoop_req_t    = ace_snoop_req_t,
  parameter type         snoop_resp_t   = ace_snoop_resp_t
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  snoop_req_t  slv_snp_req_i,
  output snoop_resp_t slv_snp_resp_o,
  output snoop_req_t  mst_snp_req_o,
  input  snoop_resp_t mst_snp_resp_i,
  output logic [7:0]  outstanding_o,
  output logic [7:0]  cd_credit_o,
  output logic        proto_err_o
);

  localparam snoop_cnt_t MaxOut = snoop_cnt_t'(MaxOutstanding);
  localparam snoop_cnt_t CntMax = '1;

  snoop_cnt_t out_q, out_d;
  snoop_cnt_t credit_q, credit_d;
  logic       err_q, err_d;
  logic       mid_q, mid_d;
  logic       init_q;

  ac_chan_t ac_head;
  cr_resp_t cr_head;
  cd_chan_t cd_head;
  logic     ac_full, ac_empty;
  logic     cr_full, cr_empty;
  logic     cd_full, cd_empty;

  logic slv_ac_ready, mst_ac_valid;
  logic mst_cr_ready, mst_cd_ready;
  logic slv_cr_valid, slv_cd_valid;
  logic ac_slv_hs, ac_mst_hs;
  logic cr_mst_hs, cr_slv_hs;
  logic cd_mst_hs, cd_slv_hs;
  logic cr_dt, credit_inc, credit_dec;
  logic underflow, saturate, orphan;

  assign slv_ac_ready = init_q && !ac_full;
  assign mst_cr_ready = init_q && !cr_full;
  assign mst_cd_ready = init_q && !cd_full;

  assign mst_ac_valid = !ac_empty && (out_q < MaxOut);
  assign slv_cr_valid = !cr_empty;

  assign ac_slv_hs = slv_snp_req_i.ac_valid && slv_ac_ready;
  assign ac_mst_hs = mst_ac_valid && mst_snp_resp_i.ac_ready;
  assign cr_mst_hs = mst_snp_resp_i.cr_valid && mst_cr_ready;
  assign cr_slv_hs = slv_cr_valid && slv_snp_req_i.cr_ready;
  assign cd_mst_hs = mst_snp_resp_i.cd_valid && mst_cd_ready;

  assign cr_dt      = cr_has_data(cr_head);
  assign credit_inc = cr_slv_hs && cr_dt;

  assign slv_cd_valid = !cd_empty &&
                        ((credit_q != '0) || credit_inc);
  assign cd_slv_hs    = slv_cd_valid && slv_snp_req_i.cd_ready;
  assign credit_dec   = cd_slv_hs && cd_head.last;

  snoop_sync_fifo #(
    .Depth (AcDepth),
    .T     (ac_chan_t)
  ) u_ac_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (ac_slv_hs),
    .data_i  (slv_snp_req_i.ac),
    .pop_i   (ac_mst_hs),
    .data_o  (ac_head),
    .full_o  (ac_full),
    .empty_o (ac_empty)
  );

  snoop_sync_fifo #(
    .Depth (CrDepth),
    .T     (cr_resp_t)
  ) u_cr_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (cr_mst_hs),
    .data_i  (mst_snp_resp_i.cr_resp),
    .pop_i   (cr_slv_hs),
    .data_o  (cr_head),
    .full_o  (cr_full),
    .empty_o (cr_empty)
  );

  snoop_sync_fifo #(
    .Depth (CdDepth),
    .T     (cd_chan_t)
  ) u_cd_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (cd_mst_hs),
    .data_i  (mst_snp_resp_i.cd),
    .pop_i   (cd_slv_hs),
    .data_o  (cd_head),
    .full_o  (cd_full),
    .empty_o (cd_empty)
  );

  // Snoops at the cache: up on AC, down on CR, clamp at zero
  always_comb begin
    out_d     = out_q;
    underflow = 1'b0;
    unique case (1'b1)
      (ac_mst_hs && !cr_mst_hs): out_d = out_q + snoop_cnt_t'(1);
      (cr_mst_hs && !ac_mst_hs): begin
        if (out_q == '0) begin
          underflow = 1'b1;
        end else begin
          out_d = out_q - snoop_cnt_t'(1);
        end
      end
      default: out_d = out_q;
    endcase
  end

  // CD credits: one per data-carrying CR, returned on last beat
  always_comb begin
    credit_d = credit_q;
    saturate = 1'b0;
    unique case (1'b1)
      (credit_inc && !credit_dec): begin
        if (credit_q == CntMax) begin
          saturate = 1'b1;
        end else begin
          credit_d = credit_q + snoop_cnt_t'(1);
        end
      end
      (credit_dec && !credit_inc): credit_d = credit_q - snoop_cnt_t'(1);
      default:                     credit_d = credit_q;
    endcase
  end

  // Burst tracking and sticky error detection
  always_comb begin
    mid_d = mid_q;
    if (cd_slv_hs) begin
      mid_d = !cd_head.last;
    end
    orphan = cr_slv_hs && !cr_dt && (credit_q == '0) &&
             !cd_empty && !mid_q;
    err_d  = err_q || underflow || saturate || orphan;
  end

  // Counter, error and ready-enable registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_q    <= '0;
      credit_q <= '0;
      err_q    <= 1'b0;
      mid_q    <= 1'b0;
      init_q   <= 1'b0;
    end else begin
      out_q    <= out_d;
      credit_q <= credit_d;
      err_q    <= err_d;
      mid_q    <= mid_d;
      init_q   <= 1'b1;
    end
  end

  // Output bundles toward CCU and cache
  always_comb begin
    slv_snp_resp_o          = '0;
    slv_snp_resp_o.ac_ready = slv_ac_ready;
    slv_snp_resp_o.cr_valid = slv_cr_valid;
    slv_snp_resp_o.cr_resp  = cr_head;
    slv_snp_resp_o.cd_valid = slv_cd_valid;
    slv_snp_resp_o.cd       = cd_head;
    mst_snp_req_o           = '0;
    mst_snp_req_o.ac_valid  = mst_ac_valid;
    mst_snp_req_o.ac        = ac_head;
    mst_snp_req_o.cr_ready  = mst_cr_ready;
    mst_snp_req_o.cd_ready  = mst_cd_ready;
  end

  assign outstanding_o = out_q;
  assign cd_credit_o   = credit_q;
  assign proto_err_o   = err_q;

endmodule
